// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int FIFO_AF_MARGIN = 4;
  localparam int FIFO_AE_LEVEL  = 4;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array itself is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset, matching BRAM output-register reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds
// and per-cycle overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - FIFO_AF_MARGIN,
  parameter int AE_LEVEL = FIFO_AE_LEVEL,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH=%0d must be a power of two >= 4", DEPTH);
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL=%0d out of range 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL=%0d out of range 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Full/empty come from count alone, so pointers simply wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      dout_valid <= rd_acc;
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: queue-based reference model, decoupled
// output monitor checking dout ordering and hold behaviour.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEP   = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEP) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_q [$];  // contents the FIFO should hold
  logic [DW-1:0] exp_q   [$];  // data expected on dout, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_flags(input int occ);
    check("count",        32'(count),        32'(occ));
    check("empty",        32'(empty),        32'(occ == 0));
    check("full",         32'(full),         32'(occ == DEP));
    check("almost_full",  32'(almost_full),  32'(occ >= AF));
    check("almost_empty", 32'(almost_empty), 32'(occ <= AE));
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit m_full, m_empty, wa, ra;
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    m_full  = (model_q.size() == DEP);
    m_empty = (model_q.size() == 0);
    wa = w && !m_full;
    ra = r && !m_empty;
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    @(posedge clk);
    #1;
    check_flags(model_q.size());
    check("overflow",   32'(overflow),   32'(w && m_full));
    check("underflow",  32'(underflow),  32'(r && m_empty));
    check("dout_valid", 32'(dout_valid), 32'(ra));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #1;
    model_q.delete();
    exp_q.delete();
    check_flags(0);
    check("rst_dout",       32'(dout),       32'(0));
    check("rst_dout_valid", 32'(dout_valid), 32'(0));
    check("rst_overflow",   32'(overflow),   32'(0));
    check("rst_underflow",  32'(underflow),  32'(0));
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: pops an expectation for every dout_valid, otherwise dout must hold.
  logic [DW-1:0] last_dout = '0;
  always @(negedge clk) begin
    if (!rst) begin
      last_dout = '0;
    end else if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_dout_valid", 32'(1), 32'(0));
      end else begin
        check("dout_data", 32'(dout), 32'(exp_q.pop_front()));
      end
      last_dout = dout;
    end else begin
      check("dout_hold", 32'(dout), 32'(last_dout));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);

    // Fill 0x01..0x08, try a write while full, drain fully, then read while empty.
    for (int unsigned i = 1; i <= DEP; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b0, 8'hAA);
    for (int unsigned i = 0; i < DEP; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Steady state at count=4 with simultaneous traffic (pointers wrap several times).
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom));
    for (int unsigned i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom));
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

    // Simultaneous at empty, then at full.
    step(1'b1, 1'b1, 8'h5C);
    for (int unsigned i = 0; i < DEP - 1; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, 8'hEE);
    for (int unsigned i = 0; i < DEP; i++) step(1'b0, 1'b1, '0);

    // Randomised push/pop traffic.
    for (int unsigned i = 0; i < 100; i++)
      step(1'($urandom), 1'($urandom), DW'($urandom));

    // Reset mid-stream with five entries held, then confirm clean restart.
    for (int unsigned i = 0; i < DEP; i++) step(1'b0, 1'b1, '0);
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b0, 1'b0, '0);
    do_reset();
    step(1'b1, 1'b0, 8'h3D);
    step(1'b1, 1'b0, 8'h4E);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    repeat (3) step(1'b0, 1'b0, '0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the successor to the team's fixed 8-bit x 1 KB buffer.
- Adds configurable data width and depth, a full read path, occupancy count and programmable almost-full/almost-empty levels.
- Adds per-cycle overflow/underflow error pulses and defined simultaneous read/write behaviour.
- Sits between producer and consumer stages in the same clock domain; all status outputs come from registered state.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 1024, number of entries; power of two, >=4
AF_LEVEL, DEPTH-4, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
CNT_W, $clog2(DEPTH)+1, derived localparam, width of count

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
wr_en  in  1  write request
din  in  DATA_W  write data
rd_en  in  1  read request
dout  out  DATA_W  read data, registered
dout_valid  out  1  one-cycle pulse; dout updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected because full
underflow  out  1  one-cycle pulse: read rejected because empty

Behaviour:
- Reset (rst low, async assert, sync release):
  - wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Storage array is NOT reset; contents are don't-care until written.
- Write accepted (wr_acc) iff wr_en && !full. On wr_acc: mem[wr_ptr]<=din; wr_ptr<=wr_ptr+1.
- Read accepted (rd_acc) iff rd_en && !empty. On rd_acc: dout<=mem[rd_ptr]; rd_ptr<=rd_ptr+1; dout_valid<=1. Otherwise dout_valid<=0.
- Read latency: data appears on dout the cycle after the accepting edge. dout holds its last value when no read is accepted.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty derive from count only, never from pointer compare.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Simultaneous wr_en && rd_en:
  - Empty: only the write is accepted (no write-through to dout). count 0->1, underflow pulses.
  - Full: only the read is accepted. count DEPTH->DEPTH-1, overflow pulses. The rejected write is lost; the producer must retry.
  - Otherwise: both accepted, count unchanged.
- overflow<=wr_en && full; underflow<=rd_en && empty. Both are registered, high for exactly one cycle per offending request cycle, and never sticky.
- Flags (full, empty, almost_*) are combinational decodes of registered count, valid in the same cycle count changes.
- Reset asserted mid-operation: all state above returns to reset values immediately. In-flight dout_valid is dropped; stored data is treated as discarded.
- Elaboration check: fatal error if DEPTH is not a power of two, or if AF_LEVEL/AE_LEVEL are out of range.

Decomposition:
- Shared package fifo_pkg:
  - function is_pow2(int)
  - default threshold constants FIFO_AF_MARGIN=4, FIFO_AE_LEVEL=4
- One sub-module fifo_ram: simple dual-port array, DATA_W x DEPTH, one synchronous write port, one registered read port with read enable. Keeps inference clean for block RAM.
- Pointer, count and flag logic stays in sync_fifo_param.

Test Plan:
(Bench instantiates DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.)
1. Reset, then idle. Expect: empty=1, almost_empty=1, full=0, count=0, dout=0, no pulses. Assert rst low mid-stream with count=5 -> count=0, empty=1 in the same cycle.
2. Fill and drain:
   - Write 0x01..0x08 on consecutive cycles -> almost_empty drops at count=2; almost_full rises at count=6; full at count=8.
   - Read 8 times -> dout sequence 0x01..0x08, each one cycle after its rd_en, with dout_valid pulses; empty at end.
3. Overflow/underflow:
   - wr_en with full, din=0xAA -> overflow pulse; count stays 8; 0xAA never read out.
   - rd_en with empty -> underflow pulse; dout holds its previous value; dout_valid=0.
4. Simultaneous read/write:
   - At count=4, wr_en && rd_en for 20 cycles -> count stays 4; data order preserved; pointers wrap at least twice.
   - At empty -> count becomes 1 and underflow pulses.
   - At full -> count becomes 7 and overflow pulses.
5. Wrap-around integrity: 100 random pushes/pops, scoreboard against a reference queue -> every dout matches, count matches queue size every cycle.
